// File: rtl/nvram_backup_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nvram_backup_ctrl
// Brief    : Save-RAM <-> SD image sector sequencer (load on mount, save on req)
// Revision : 1.0
// ============================================================================
module nvram_backup_ctrl #(
    parameter int          SECTORS = 16,
    parameter logic [23:0] TIMEOUT = 24'd8000000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        img_mounted,
    input  logic [31:0] img_size,
    input  logic        ioctl_download,
    input  logic        save_req,
    input  logic        nvram_we,
    input  logic        sd_ack,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic [5:0]  buf_sector,
    output logic        bk_ena,
    output logic        bk_busy,
    output logic        bk_dirty,
    output logic        bk_reset,
    output logic        bk_error
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_XFER = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [5:0] c_LAST_SECTOR = 6'(SECTORS - 1);

    logic [1:0]  r_state, w_state;
    logic [5:0]  r_lba, w_lba;
    logic        r_rd, w_rd;
    logic        r_wr, w_wr;
    logic        r_load, w_load;
    logic        r_pending, w_pending;
    logic        r_we_seen, w_we_seen;
    logic [23:0] r_timer, w_timer;
    logic        r_ena, w_ena;
    logic        r_dirty, w_dirty;
    logic        r_reset_p, w_reset_p;
    logic        r_error, w_error;
    logic        r_mount_d, r_save_d, r_ack_d, r_dl_d;
    logic        w_dirty_clr;

    logic w_mount_rise, w_save_rise, w_ack_rise, w_ack_fall, w_dl_rise;

    assign w_mount_rise = img_mounted & ~r_mount_d;
    assign w_save_rise  = save_req & ~r_save_d;
    assign w_ack_rise   = sd_ack & ~r_ack_d;
    assign w_ack_fall   = ~sd_ack & r_ack_d;
    assign w_dl_rise    = ioctl_download & ~r_dl_d;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_lba     <= 6'd0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_load    <= 1'b0;
            r_pending <= 1'b0;
            r_we_seen <= 1'b0;
            r_timer   <= 24'd0;
            r_ena     <= 1'b0;
            r_dirty   <= 1'b0;
            r_reset_p <= 1'b0;
            r_error   <= 1'b0;
            r_mount_d <= 1'b0;
            r_save_d  <= 1'b0;
            r_ack_d   <= 1'b0;
            r_dl_d    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_lba     <= w_lba;
            r_rd      <= w_rd;
            r_wr      <= w_wr;
            r_load    <= w_load;
            r_pending <= w_pending;
            r_we_seen <= w_we_seen;
            r_timer   <= w_timer;
            r_ena     <= w_ena;
            r_dirty   <= w_dirty;
            r_reset_p <= w_reset_p;
            r_error   <= w_error;
            r_mount_d <= img_mounted;
            r_save_d  <= save_req;
            r_ack_d   <= sd_ack;
            r_dl_d    <= ioctl_download;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_lba       = r_lba;
        w_rd        = r_rd;
        w_wr        = r_wr;
        w_load      = r_load;
        w_pending   = r_pending;
        w_we_seen   = r_we_seen;
        w_timer     = r_timer;
        w_ena       = r_ena;
        w_dirty     = r_dirty;
        w_reset_p   = 1'b0;
        w_error     = r_error;
        w_dirty_clr = 1'b0;

        // A save edge is always remembered; IDLE consumes it when it can act on it.
        if (w_save_rise) begin
            w_pending = 1'b1;
        end

        case (r_state)
            c_IDLE: begin
                if (w_mount_rise) begin
                    w_ena = 1'b1;
                    if (img_size != 32'd0) begin
                        w_load    = 1'b1;
                        w_lba     = 6'd0;
                        w_rd      = 1'b1;
                        w_wr      = 1'b0;
                        w_timer   = 24'd0;
                        w_we_seen = 1'b0;
                        w_state   = c_REQ;
                    end else begin
                        w_dirty = 1'b1;
                    end
                end else if (r_pending || w_save_rise) begin
                    w_pending = 1'b0;
                    if (r_ena) begin
                        w_load    = 1'b0;
                        w_lba     = 6'd0;
                        w_rd      = 1'b0;
                        w_wr      = 1'b1;
                        w_timer   = 24'd0;
                        w_we_seen = 1'b0;
                        w_state   = c_REQ;
                    end
                end
            end
            c_REQ: begin
                if (w_ack_rise) begin
                    w_rd    = 1'b0;
                    w_wr    = 1'b0;
                    w_timer = 24'd0;
                    w_state = c_XFER;
                end else if (r_timer == TIMEOUT - 24'd1) begin
                    w_rd    = 1'b0;
                    w_wr    = 1'b0;
                    w_error = 1'b1;
                    w_state = c_IDLE;
                end else begin
                    w_timer = r_timer + 24'd1;
                end
            end
            c_XFER: begin
                if (w_ack_fall) begin
                    if (r_lba == c_LAST_SECTOR) begin
                        w_reset_p = r_load;
                        w_state   = c_DONE;
                    end else begin
                        w_lba   = r_lba + 6'd1;
                        w_rd    = r_load;
                        w_wr    = ~r_load;
                        w_timer = 24'd0;
                        w_state = c_REQ;
                    end
                end
            end
            default: begin
                // A write that landed mid-save means the image is already stale.
                w_dirty_clr = r_load | ~r_we_seen;
                w_error     = 1'b0;
                w_state     = c_IDLE;
            end
        endcase

        if (nvram_we && (r_state != c_IDLE)) begin
            w_we_seen = 1'b1;
        end
        if (w_dirty_clr) begin
            w_dirty = 1'b0;
        end
        if (nvram_we) begin
            w_dirty = 1'b1;
        end

        if (w_dl_rise) begin
            w_ena     = 1'b0;
            w_rd      = 1'b0;
            w_wr      = 1'b0;
            w_pending = 1'b0;
            w_reset_p = 1'b0;
            w_state   = c_IDLE;
        end
    end

    assign sd_lba     = {26'd0, r_lba};
    assign buf_sector = r_lba;
    assign sd_rd      = r_rd;
    assign sd_wr      = r_wr;
    assign bk_ena     = r_ena;
    assign bk_busy    = (r_state != c_IDLE);
    assign bk_dirty   = r_dirty;
    assign bk_reset   = r_reset_p;
    assign bk_error   = r_error;

endmodule
`default_nettype wire

// File: tb/tb_nvram_backup_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nvram_backup_ctrl
// Brief    : Randomised-ack bench for nvram_backup_ctrl with a request-list model
// Revision : 1.0
// ============================================================================
module tb_nvram_backup_ctrl;

    localparam int c_SECTORS = 16;
    localparam int c_TIMEOUT = 100;

    logic        clk_sys, reset;
    logic        img_mounted, ioctl_download, save_req, nvram_we, sd_ack;
    logic [31:0] img_size;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic [5:0]  buf_sector;
    logic        bk_ena, bk_busy, bk_dirty, bk_reset, bk_error;

    nvram_backup_ctrl #(
        .SECTORS (c_SECTORS),
        .TIMEOUT (24'(c_TIMEOUT))
    ) u_dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .img_mounted    (img_mounted),
        .img_size       (img_size),
        .ioctl_download (ioctl_download),
        .save_req       (save_req),
        .nvram_we       (nvram_we),
        .sd_ack         (sd_ack),
        .sd_lba         (sd_lba),
        .sd_rd          (sd_rd),
        .sd_wr          (sd_wr),
        .buf_sector     (buf_sector),
        .bk_ena         (bk_ena),
        .bk_busy        (bk_busy),
        .bk_dirty       (bk_dirty),
        .bk_reset       (bk_reset),
        .bk_error       (bk_error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // observed request starts as {is_write, lba}; expected list built by the model
    logic [32:0] req_q[$];
    logic [32:0] exp_q[$];
    int          cyc = 0;
    int          rst_pulses = 0;
    int          rst_cyc = -1;
    int          last_fall_cyc = -1;
    int          both_cnt = 0;
    logic        prev_rd = 1'b0;
    logic        prev_wr = 1'b0;
    bit          sd_en = 1'b1;

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin : monitor
        forever begin
            @(posedge clk_sys);
            cyc++;
            #1;
            if (sd_rd && !prev_rd) req_q.push_back({1'b0, sd_lba});
            if (sd_wr && !prev_wr) req_q.push_back({1'b1, sd_lba});
            if (sd_rd && sd_wr) both_cnt++;
            if (bk_reset) begin
                rst_pulses++;
                rst_cyc = cyc;
            end
            prev_rd = sd_rd;
            prev_wr = sd_wr;
        end
    end

    // SD card: random ack delay 1..6 and ack width 1..20 per request
    initial begin : sd_model
        int dly;
        int len;
        sd_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (sd_en && (sd_rd || sd_wr)) begin
                dly = int'($urandom_range(6, 1));
                len = int'($urandom_range(20, 1));
                repeat (dly - 1) @(negedge clk_sys);
                sd_ack = 1'b1;
                repeat (len) @(negedge clk_sys);
                sd_ack = 1'b0;
                last_fall_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #2;
    endtask

    // reference: every transfer touches sectors 0..SECTORS-1 in order with one request kind
    task automatic model_transfer(input bit is_save);
        for (int i = 0; i < c_SECTORS; i++) exp_q.push_back({is_save, 32'(i)});
    endtask

    task automatic mount_pulse(input logic [31:0] size);
        @(negedge clk_sys);
        img_size    = size;
        img_mounted = 1'b1;
        @(negedge clk_sys);
        img_mounted = 1'b0;
    endtask

    task automatic save_pulse();
        @(negedge clk_sys);
        save_req = 1'b1;
        @(negedge clk_sys);
        save_req = 1'b0;
    endtask

    task automatic we_pulse();
        @(negedge clk_sys);
        nvram_we = 1'b1;
        @(negedge clk_sys);
        nvram_we = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int quiet = 0;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (bk_busy) quiet = 0; else quiet++;
            if (quiet >= 4) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_sector(input int lba, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (sd_lba == 32'(lba) && (sd_rd || sd_wr)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_checks++; if (sd_rd !== 1'b0)    begin n_fail++; $display("FAIL reset_sd_rd: got %b want 0", sd_rd); end
        n_checks++; if (sd_wr !== 1'b0)    begin n_fail++; $display("FAIL reset_sd_wr: got %b want 0", sd_wr); end
        n_checks++; if (sd_lba !== 32'd0)  begin n_fail++; $display("FAIL reset_sd_lba: got %0d want 0", sd_lba); end
        n_checks++; if ({bk_ena, bk_busy, bk_dirty, bk_reset, bk_error} !== 5'b0)
            begin n_fail++; $display("FAIL reset_bk_flags: got %b want 00000", {bk_ena, bk_busy, bk_dirty, bk_reset, bk_error}); end
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_load();
        bit ok;
        int base;
        we_pulse();
        step();
        n_checks++; if (bk_dirty !== 1'b1) begin n_fail++; $display("FAIL load_pre_dirty: got %b want 1", bk_dirty); end
        req_q.delete(); exp_q.delete();
        base = rst_pulses;
        model_transfer(1'b0);
        mount_pulse($urandom | 32'd1);
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL load_timeout: busy did not clear"); end
        n_checks++; if (req_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL load_count: got %0d want %0d", req_q.size(), exp_q.size()); end
        for (int i = 0; i < req_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (req_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL load_req[%0d]: got %h want %h", i, req_q[i], exp_q[i]); end
        end
        n_checks++; if (rst_pulses - base !== 1) begin n_fail++; $display("FAIL load_reset_pulses: got %0d want 1", rst_pulses - base); end
        n_checks++; if (rst_cyc !== last_fall_cyc + 1) begin n_fail++; $display("FAIL load_reset_timing: got cycle %0d want %0d", rst_cyc, last_fall_cyc + 1); end
        n_checks++; if (bk_ena !== 1'b1)   begin n_fail++; $display("FAIL load_ena: got %b want 1", bk_ena); end
        n_checks++; if (bk_dirty !== 1'b0) begin n_fail++; $display("FAIL load_dirty: got %b want 0", bk_dirty); end
        n_checks++; if (buf_sector !== 6'(c_SECTORS - 1)) begin n_fail++; $display("FAIL load_buf_sector: got %0d want %0d", buf_sector, c_SECTORS - 1); end
    endtask

    task automatic test_save_dirty();
        bit ok;
        int base;
        req_q.delete(); exp_q.delete();
        base = rst_pulses;
        model_transfer(1'b1);
        save_pulse();
        wait_sector(5, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL save_sector5_timeout: sector 5 never requested"); end
        we_pulse();
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL save_timeout: busy did not clear"); end
        n_checks++; if (req_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL save_count: got %0d want %0d", req_q.size(), exp_q.size()); end
        for (int i = 0; i < req_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (req_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL save_req[%0d]: got %h want %h", i, req_q[i], exp_q[i]); end
        end
        n_checks++; if (bk_dirty !== 1'b1) begin n_fail++; $display("FAIL save_we_dirty: got %b want 1", bk_dirty); end
        n_checks++; if (rst_pulses - base !== 0) begin n_fail++; $display("FAIL save_reset_pulses: got %0d want 0", rst_pulses - base); end
        save_pulse();
        wait_idle(ok);
        n_checks++; if (bk_dirty !== 1'b0) begin n_fail++; $display("FAIL save_clean_dirty: got %b want 0", bk_dirty); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int base;
        req_q.delete(); exp_q.delete();
        base = rst_pulses;
        model_transfer(1'b0);
        model_transfer(1'b1);
        @(negedge clk_sys);
        img_size    = 32'd8192;
        img_mounted = 1'b1;
        save_req    = 1'b1;
        @(negedge clk_sys);
        img_mounted = 1'b0;
        save_req    = 1'b0;
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout: busy did not clear"); end
        n_checks++; if (req_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", req_q.size(), exp_q.size()); end
        for (int i = 0; i < req_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (req_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_req[%0d]: got %h want %h", i, req_q[i], exp_q[i]); end
        end
        n_checks++; if (rst_pulses - base !== 1) begin n_fail++; $display("FAIL b2b_reset_pulses: got %0d want 1", rst_pulses - base); end
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL b2b_rd_wr_overlap: got %0d want 0", both_cnt); end
    endtask

    task automatic test_download_abort();
        bit ok;
        int base;
        base = rst_pulses;
        mount_pulse(32'd8192);
        wait_sector(7, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL dl_sector7_timeout: sector 7 never requested"); end
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        step();
        n_checks++; if (sd_rd !== 1'b0)   begin n_fail++; $display("FAIL dl_sd_rd: got %b want 0", sd_rd); end
        n_checks++; if (bk_ena !== 1'b0)  begin n_fail++; $display("FAIL dl_ena: got %b want 0", bk_ena); end
        n_checks++; if (bk_busy !== 1'b0) begin n_fail++; $display("FAIL dl_busy: got %b want 0", bk_busy); end
        repeat (40) step();
        n_checks++; if (rst_pulses - base !== 0) begin n_fail++; $display("FAIL dl_reset_pulses: got %0d want 0", rst_pulses - base); end
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        req_q.delete();
        save_pulse();
        repeat (40) step();
        n_checks++; if (req_q.size() !== 0) begin n_fail++; $display("FAIL dl_save_ignored: got %0d requests want 0", req_q.size()); end
    endtask

    task automatic test_timeout();
        bit ok;
        int base;
        int hi = 0;
        sd_en = 1'b0;
        base = rst_pulses;
        mount_pulse(32'd4096);
        for (int i = 0; i < 400; i++) begin
            if (sd_rd) hi++;
            else if (hi > 0) break;
            step();
        end
        n_checks++; if (hi !== c_TIMEOUT) begin n_fail++; $display("FAIL to_rd_cycles: got %0d want %0d", hi, c_TIMEOUT); end
        step();
        n_checks++; if (bk_error !== 1'b1) begin n_fail++; $display("FAIL to_error: got %b want 1", bk_error); end
        n_checks++; if (bk_busy !== 1'b0)  begin n_fail++; $display("FAIL to_busy: got %b want 0", bk_busy); end
        n_checks++; if (rst_pulses - base !== 0) begin n_fail++; $display("FAIL to_reset_pulses: got %0d want 0", rst_pulses - base); end
        sd_en = 1'b1;
        req_q.delete();
        save_pulse();
        wait_idle(ok);
        n_checks++; if (req_q.size() !== c_SECTORS) begin n_fail++; $display("FAIL to_save_count: got %0d want %0d", req_q.size(), c_SECTORS); end
        n_checks++; if (bk_error !== 1'b0) begin n_fail++; $display("FAIL to_error_clear: got %b want 0", bk_error); end
    endtask

    task automatic test_zero_size();
        req_q.delete();
        n_checks++; if (bk_dirty !== 1'b0) begin n_fail++; $display("FAIL zero_pre_dirty: got %b want 0", bk_dirty); end
        mount_pulse(32'd0);
        repeat (30) step();
        n_checks++; if (bk_ena !== 1'b1)   begin n_fail++; $display("FAIL zero_ena: got %b want 1", bk_ena); end
        n_checks++; if (bk_dirty !== 1'b1) begin n_fail++; $display("FAIL zero_dirty: got %b want 1", bk_dirty); end
        n_checks++; if (req_q.size() !== 0) begin n_fail++; $display("FAIL zero_requests: got %0d want 0", req_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int base;
        base = rst_pulses;
        mount_pulse(32'd8192);
        wait_sector(3, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_sector3_timeout: sector 3 never requested"); end
        @(negedge clk_sys);
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({sd_rd, sd_wr, bk_ena, bk_busy, bk_dirty} !== 5'b0)
            begin n_fail++; $display("FAIL rmid_async_outputs: got %b want 00000", {sd_rd, sd_wr, bk_ena, bk_busy, bk_dirty}); end
        n_checks++; if (sd_lba !== 32'd0) begin n_fail++; $display("FAIL rmid_lba: got %0d want 0", sd_lba); end
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (40) step();
        n_checks++; if (rst_pulses - base !== 0) begin n_fail++; $display("FAIL rmid_reset_pulses: got %0d want 0", rst_pulses - base); end
        n_checks++; if (bk_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", bk_busy); end
    endtask

    initial begin
        reset          = 1'b1;
        img_mounted    = 1'b0;
        img_size       = 32'd0;
        ioctl_download = 1'b0;
        save_req       = 1'b0;
        nvram_we       = 1'b0;
        test_reset();
        test_load();
        test_save_dirty();
        test_back_to_back();
        test_download_abort();
        test_timeout();
        test_zero_size();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
